// File: rtl/patch_proto_pkg.sv
// patch_proto_pkg: patch-link word encoding shared by transmitter and receiver.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package patch_proto_pkg;

  // Transmitter frame phase; the receiver decodes the same phases from meta codes.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SOF  = 2'd1,
    ST_DATA = 2'd2,
    ST_EOF  = 2'd3
  } tx_state_t;

  // Patch code width; never zero so a single-patch build still has a code field.
  function automatic int patch_code_width(input int n_patch);
    return (n_patch > 1) ? $clog2(n_patch) : 1;
  endfunction

  // SOF is the all-ones code of a pw-bit field.
  function automatic logic [31:0] sof_code(input int pw);
    return (32'd1 << pw) - 32'd1;
  endfunction

  // EOF is all ones with the LSB cleared.
  function automatic logic [31:0] eof_code(input int pw);
    return sof_code(pw) & ~32'd1;
  endfunction

  // The two top codes are reserved for framing; everything below is a patch number.
  function automatic logic is_meta(input logic [31:0] code, input int pw);
    return (code == sof_code(pw)) || (code == eof_code(pw));
  endfunction

  function automatic logic is_sof(input logic [31:0] code, input int pw);
    return code == sof_code(pw);
  endfunction

endpackage

// File: rtl/gap_counter.sv
// gap_counter: enforces GAP idle cycles after each emitted word.
// Latency: zero flag drops the cycle after load and returns GAP cycles later.
// Backpressure: none; the owner holds off emission while zero is low.
module gap_counter #(
  parameter int  GAP = 0,
  localparam int W   = (GAP > 0) ? $clog2(GAP + 1) : 1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic load,
  output logic zero
);

  logic [W-1:0] cnt_q;

  // Reload on every emitted word, otherwise count down to zero and hold.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= W'(GAP);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cam_patch_tx.sv
// cam_patch_tx: per-camera frame source; SOF meta, N_PATCH {patch_num, wtsum} words, EOF meta.
// Latency: SOF one cycle after start; an accepted input word is on output_data one cycle later.
// Backpressure: no downstream stall; upstream gets in_ready only in the data phase with the gap expired.
// Build option CAM_PATCH_TX_SHUFFLE_EN: data patches leave pair-swapped (1,0,3,2,...).
module cam_patch_tx
  import patch_proto_pkg::*;
#(
  parameter int  DELAY   = 1,
  parameter int  N_PATCH = 1,
  parameter int  FP_SIZE = 1,
  parameter int  GAP     = 0,
  localparam int PW      = patch_code_width(N_PATCH),
  localparam int DW      = PW + FP_SIZE
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               start,
  input  logic               in_valid,
  input  logic [FP_SIZE-1:0] in_wtsum,
  output logic               in_ready,
  output logic               output_valid,
  output logic [DW-1:0]      output_data,
  output logic               busy,
  output logic               start_overrun
);

  localparam logic [PW-1:0] SOF_CODE = PW'(sof_code(PW));
  localparam logic [PW-1:0] EOF_CODE = PW'(eof_code(PW));
  localparam logic [PW-1:0] N_CODE   = PW'(N_PATCH);

  // Patch numbers must stay clear of the two framing codes.
  if (N_PATCH > (1 << PW) - 2) begin : g_bad_n_patch
    $error("cam_patch_tx: N_PATCH overlaps the SOF/EOF codes");
  end
  // DELAY only affects simulation models; registers here are zero-delay.
  if (DELAY < 0) begin : g_bad_delay
    $error("cam_patch_tx: DELAY must be non-negative");
  end

  tx_state_t          state_q, state_d;
  logic [PW-1:0]      cnt_q, cnt_d;
  logic [FP_SIZE-1:0] frame_q, frame_d;
  logic               vld_d;
  logic [DW-1:0]      dat_d;
  logic               ovr_d;
  logic               load_gap;
  logic               gap_zero;
  logic               accept;
  logic               data_phase;
  logic               eof_ok;

`ifdef CAM_PATCH_TX_SHUFFLE_EN
  localparam logic [PW-1:0] LAST_CODE = PW'(N_PATCH - 1);
  logic [FP_SIZE-1:0] hold_wts_q, hold_wts_d;
  logic [PW-1:0]      hold_num_q, hold_num_d;
  logic               flush_q, flush_d;
`endif

  gap_counter #(
    .GAP (GAP)
  ) u_gap (
    .CLK   (CLK),
    .RESET (RESET),
    .load  (load_gap),
    .zero  (gap_zero)
  );

  // SOF state counts as data phase: patch 0 may be taken as soon as the SOF gap expires.
  assign data_phase = (state_q == ST_SOF) || (state_q == ST_DATA);
`ifdef CAM_PATCH_TX_SHUFFLE_EN
  // A pending held word owns the next output slot, so upstream is paused for it.
  assign in_ready = data_phase && gap_zero && (cnt_q < N_CODE) && !flush_q;
  assign eof_ok   = !flush_q;
`else
  assign in_ready = data_phase && gap_zero && (cnt_q < N_CODE);
  assign eof_ok   = 1'b1;
`endif
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != ST_IDLE);
  assign load_gap = vld_d;

  // Next-state, counters and the word to emit next cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    vld_d   = 1'b0;
    dat_d   = '0;
    ovr_d   = start_overrun | (start & busy);
`ifdef CAM_PATCH_TX_SHUFFLE_EN
    hold_wts_d = hold_wts_q;
    hold_num_d = hold_num_q;
    flush_d    = flush_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SOF;
          vld_d   = 1'b1;
          dat_d   = {SOF_CODE, frame_q};
        end
      end
      ST_SOF: begin
        if (gap_zero) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (gap_zero && (cnt_q == N_CODE) && eof_ok) begin
          state_d = ST_EOF;
          vld_d   = 1'b1;
          dat_d   = {EOF_CODE, {FP_SIZE{1'b0}}};
          cnt_d   = '0;
          frame_d = frame_q + FP_SIZE'(1);
        end
      end
      ST_EOF: begin
        if (gap_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      cnt_d = cnt_q + PW'(1);
`ifdef CAM_PATCH_TX_SHUFFLE_EN
      // Even patches wait for their odd partner; an unpaired last patch goes straight out.
      if (!cnt_q[0] && (cnt_q != LAST_CODE)) begin
        hold_wts_d = in_wtsum;
        hold_num_d = cnt_q;
      end else begin
        vld_d   = 1'b1;
        dat_d   = {cnt_q, in_wtsum};
        flush_d = cnt_q[0];
      end
`else
      vld_d = 1'b1;
      dat_d = {cnt_q, in_wtsum};
`endif
    end
`ifdef CAM_PATCH_TX_SHUFFLE_EN
    else if (flush_q && gap_zero) begin
      vld_d   = 1'b1;
      dat_d   = {hold_num_q, hold_wts_q};
      flush_d = 1'b0;
    end
`endif
  end

  // State, counters and registered output word; RESET abandons any frame in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      frame_q       <= '0;
      output_valid  <= 1'b0;
      output_data   <= '0;
      start_overrun <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_q       <= frame_d;
      output_valid  <= vld_d;
      output_data   <= dat_d;
      start_overrun <= ovr_d;
    end
  end

`ifdef CAM_PATCH_TX_SHUFFLE_EN
  // One-entry hold register for the even member of each swapped pair.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hold_wts_q <= '0;
      hold_num_q <= '0;
      flush_q    <= 1'b0;
    end else begin
      hold_wts_q <= hold_wts_d;
      hold_num_q <= hold_num_d;
      flush_q    <= flush_d;
    end
  end
`endif

endmodule

// File: tb/tb_cam_patch_tx.sv
// tb_cam_patch_tx: scoreboard bench for cam_patch_tx, N_PATCH=6, FP_SIZE=20.
// Instance a uses GAP=0, instance b uses GAP=2; both share CLK and RESET.
// Stimulus tasks queue expected words; monitors pop and compare on output_valid.
module tb_cam_patch_tx;

  localparam int NP  = 6;
  localparam int FPW = 20;
  localparam int DW  = 23;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic           RESET;
  logic           start_a, in_valid_a, in_ready_a, output_valid_a, busy_a, start_overrun_a;
  logic [FPW-1:0] in_wtsum_a;
  logic [DW-1:0]  output_data_a;
  logic           start_b, in_valid_b, in_ready_b, output_valid_b, busy_b, start_overrun_b;
  logic [FPW-1:0] in_wtsum_b;
  logic [DW-1:0]  output_data_b;

  cam_patch_tx #(.DELAY(1), .N_PATCH(NP), .FP_SIZE(FPW), .GAP(0)) dut_a (
    .CLK(CLK), .RESET(RESET), .start(start_a), .in_valid(in_valid_a), .in_wtsum(in_wtsum_a),
    .in_ready(in_ready_a), .output_valid(output_valid_a), .output_data(output_data_a),
    .busy(busy_a), .start_overrun(start_overrun_a));

  cam_patch_tx #(.DELAY(1), .N_PATCH(NP), .FP_SIZE(FPW), .GAP(2)) dut_b (
    .CLK(CLK), .RESET(RESET), .start(start_b), .in_valid(in_valid_b), .in_wtsum(in_wtsum_b),
    .in_ready(in_ready_b), .output_valid(output_valid_b), .output_data(output_data_b),
    .busy(busy_b), .start_overrun(start_overrun_b));

  int             n_chk  = 0;
  int             n_fail = 0;
  int             cyc    = 0;
  int             dwords_a;
  logic [DW-1:0]  qa[$];
  logic [DW-1:0]  qb[$];
  logic [FPW-1:0] wts[NP];
  int             ord[NP];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor a: every word must match the queue head; data words need an acceptance the cycle before.
  logic          acc_prev_a = 1'b0;
  logic [DW-1:0] want_a;
  always @(negedge CLK) begin
    if (output_valid_a) begin
      if (qa.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_unexpected_word: got %0h, expected no word (cycle %0d)", output_data_a, cyc);
      end else begin
        want_a = qa.pop_front();
        check("a_word", output_data_a, want_a);
      end
      if (output_data_a[DW-1 -: 3] < 3'(NP)) begin
        dwords_a++;
`ifndef CAM_PATCH_TX_SHUFFLE_EN
        check("a_word_needs_accept", acc_prev_a, 1'b1);
`endif
      end
    end
    acc_prev_a = in_valid_a && in_ready_a;
  end

  // Monitor b: word content plus exact GAP=2 spacing and in_ready silence inside the gap.
  int            last_b = -100;
  logic [DW-1:0] want_b;
  always @(negedge CLK) begin
    if (output_valid_b) begin
      if (qb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_unexpected_word: got %0h, expected no word (cycle %0d)", output_data_b, cyc);
      end else begin
        want_b = qb.pop_front();
        check("b_word", output_data_b, want_b);
      end
`ifndef CAM_PATCH_TX_SHUFFLE_EN
      if (output_data_b[DW-1 -: 3] != 3'd7) check("b_word_spacing", cyc - last_b, 3);
`endif
      last_b = cyc;
    end
`ifndef CAM_PATCH_TX_SHUFFLE_EN
    if (busy_b && (cyc - last_b) < 2) check("b_ready_in_gap", in_ready_b, 1'b0);
`endif
  end

  // One frame on instance a. pat gives in_valid per cycle, ovr_at re-pulses start,
  // abort_at >= 0 asserts RESET once that many data words have been seen.
  task automatic frame_a(input logic [15:0] pat, input int ovr_at, input int abort_at,
                         input logic [FPW-1:0] fr, output int vcyc, output int bcyc);
    int idx = 0;
    int c = 0;
    bit done = 0;
    vcyc = 0;
    bcyc = 0;
    dwords_a = 0;
    qa.push_back({3'd7, fr});
    for (int k = 0; k < NP; k++)
      if (abort_at < 0 || k < abort_at) qa.push_back({3'(ord[k]), wts[ord[k]]});
    if (abort_at < 0) qa.push_back({3'd6, 20'd0});
    while (!done) begin
      @(posedge CLK);
      #1;
      start_a    = (c == 0) || (c == ovr_at);
      in_valid_a = pat[c % 16];
      in_wtsum_a = (idx < NP) ? wts[idx] : '0;
      if (in_valid_a && in_ready_a) idx++;
      @(negedge CLK);
      #1;
      if (c == 1) begin
        check("a_busy_at_t1", busy_a, 1'b1);
        check("a_sof_valid_at_t1", output_valid_a, 1'b1);
      end
      if (busy_a) bcyc++;
      if (output_valid_a) vcyc++;
      if (abort_at >= 0 && dwords_a == abort_at) begin
        RESET = 1'b1;
        start_a = 1'b0;
        in_valid_a = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_mid_valid", output_valid_a, 1'b0);
        check("rst_mid_data", output_data_a, '0);
        check("rst_mid_ready", in_ready_a, 1'b0);
        check("rst_mid_busy", busy_a, 1'b0);
        check("rst_mid_overrun", start_overrun_a, 1'b0);
        done = 1;
      end else if (c > 0 && !busy_a) begin
        done = 1;
      end
      c++;
      if (!done && c > 300) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_frame_timeout: busy still %0b after %0d cycles", busy_a, c);
        done = 1;
      end
    end
    start_a = 1'b0;
    in_valid_a = 1'b0;
  endtask

  // One frame on instance b with in_valid held high.
  task automatic frame_b(output int bcyc);
    int idx = 0;
    int c = 0;
    bit done = 0;
    bcyc = 0;
    qb.push_back({3'd7, 20'd0});
    for (int k = 0; k < NP; k++) qb.push_back({3'(ord[k]), wts[ord[k]]});
    qb.push_back({3'd6, 20'd0});
    while (!done) begin
      @(posedge CLK);
      #1;
      start_b    = (c == 0);
      in_valid_b = 1'b1;
      in_wtsum_b = (idx < NP) ? wts[idx] : '0;
      if (in_ready_b) idx++;
      @(negedge CLK);
      #1;
      if (busy_b) bcyc++;
      c++;
      if (c > 1 && !busy_b) done = 1;
      if (!done && c > 300) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_frame_timeout: busy still %0b after %0d cycles", busy_b, c);
        done = 1;
      end
    end
    start_b = 1'b0;
    in_valid_b = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vc;
    int bc;
    wts = '{20'h12345, 20'hABCDE, 20'h00001, 20'hFFFFF, 20'h80000, 20'h0F0F0};
`ifdef CAM_PATCH_TX_SHUFFLE_EN
    ord = '{1, 0, 3, 2, 5, 4};
`else
    ord = '{0, 1, 2, 3, 4, 5};
`endif
    RESET = 1'b1;
    start_a = 1'b0; in_valid_a = 1'b0; in_wtsum_a = '0;
    start_b = 1'b0; in_valid_b = 1'b0; in_wtsum_b = '0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_valid", output_valid_a, 1'b0);
    check("rst_data", output_data_a, '0);
    check("rst_ready", in_ready_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_overrun", start_overrun_a, 1'b0);
    check("rst_b_valid", output_valid_b, 1'b0);

    // GAP=2 frame: spacing checked by monitor b, total busy span (6+2)*3.
    frame_b(bc);
`ifndef CAM_PATCH_TX_SHUFFLE_EN
    check("b_frame_len", bc, 24);
`endif
    check("b_overrun_clear", start_overrun_b, 1'b0);

    // Frame 0: start re-pulsed mid-DATA is ignored but flagged.
    frame_a(16'hFFFF, 4, -1, 20'd0, vc, bc);
`ifndef CAM_PATCH_TX_SHUFFLE_EN
    check("a_f0_valid_cycles", vc, 8);
    check("a_f0_busy_cycles", bc, 8);
`endif
    check("a_f0_overrun", start_overrun_a, 1'b1);
    repeat (3) @(negedge CLK);
    check("a_f0_stays_idle", busy_a, 1'b0);

    // Frame 1: fresh start gives frame count 1; start collides with the EOF cycle.
    frame_a(16'hFFFF, 8, -1, 20'd1, vc, bc);
`ifndef CAM_PATCH_TX_SHUFFLE_EN
    check("a_f1_valid_cycles", vc, 8);
    check("a_f1_busy_cycles", bc, 8);
`endif
    repeat (3) @(negedge CLK);
    check("a_f1_no_restart", busy_a, 1'b0);

    // Frame 2: upstream stalls with a fixed half-duty pattern.
    frame_a(16'b1011_0010_0110_1001, -1, -1, 20'd2, vc, bc);
    check("a_f2_valid_cycles", vc, 8);

    // Frame 3: RESET after the fourth data word; no EOF may follow.
    frame_a(16'hFFFF, -1, 4, 20'd3, vc, bc);
    check("a_abort_queue_empty", qa.size(), 0);
    repeat (3) @(negedge CLK);

    // After reset the frame counter restarts at 0.
    frame_a(16'b0110_1101_1001_0110, -1, -1, 20'd0, vc, bc);
    check("a_post_rst_overrun", start_overrun_a, 1'b0);

    repeat (5) @(negedge CLK);
    check("a_queue_drained", qa.size(), 0);
    check("b_queue_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
